// File: rtl/mem_access_unit.sv
// mem_access_unit: executes loads/stores/LL/SC as handshaked MMIO bus transactions with
// byte-lane handling, LL/SC reservation, bus timeout and pipeline stall.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        atomic_in,
  input  logic [1:0]  mmask_in,
  input  logic        zero_ext_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        fault_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_err_in
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [1:0] sz, lo, size;
  logic zext, atom, fault, resv_valid, accept, wr, mis, sc_fail, timeout;
  logic [29:0] resv_addr;
  logic [31:0] result, sh, load;
  logic [15:0] half;
  always_comb begin
    accept = state == IDLE && req_valid_in && (mem_read_in || mem_write_in);
    wr = ~mem_read_in;
    size = (atomic_in || mmask_in[1]) ? 2'd2 : mmask_in;
    mis = (size == 2'd1 && addr_in[0]) || (size == 2'd2 && addr_in[1:0] != 2'b00);
    sc_fail = atomic_in && wr && !(resv_valid && resv_addr == addr_in[31:2]);
    timeout = cnt == CW'(TIMEOUT - 1);
    next = state == IDLE ? (accept ? ((mis || sc_fail) ? DONE : REQ) : IDLE) :
           state == REQ  ? ((bus_ack_in || bus_err_in || timeout) ? DONE : REQ) : IDLE;
    sh = bus_rdata_in >> {lo, 3'b000};
    half = lo[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
    load = sz == 2'd0 ? {{24{~zext & sh[7]}}, sh[7:0]} :
           sz == 2'd1 ? {{16{~zext & half[15]}}, half} : bus_rdata_in;
    stall_out = accept || state == REQ;
    bus_req_out = state == REQ;
    rdata_valid_out = state == DONE;
    fault_out = state == DONE && fault;
    rdata_out = state == DONE ? result : 32'd0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      sz <= 2'd0;
      lo <= 2'd0;
      zext <= 1'b0;
      atom <= 1'b0;
      fault <= 1'b0;
      result <= 32'd0;
      resv_valid <= 1'b0;
      resv_addr <= 30'd0;
      bus_we_out <= 1'b0;
      bus_addr_out <= 32'd0;
      bus_be_out <= 4'd0;
      bus_wdata_out <= 32'd0;
    end else if (accept) begin
      cnt <= '0;
      sz <= size;
      lo <= addr_in[1:0];
      zext <= zero_ext_in;
      atom <= atomic_in;
      fault <= mis;
      result <= 32'd0;
      bus_we_out <= wr;
      bus_addr_out <= {addr_in[31:2], 2'b00};
      bus_be_out <= size == 2'd0 ? 4'b0001 << addr_in[1:0] :
                    size == 2'd1 ? (addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      bus_wdata_out <= size == 2'd0 ? {4{wdata_in[7:0]}} :
                       size == 2'd1 ? {2{wdata_in[15:0]}} : wdata_in;
      if (atomic_in && wr) resv_valid <= 1'b0;
    end else if (state == REQ) begin
      cnt <= cnt + 1'b1;
      if (bus_err_in || (!bus_ack_in && timeout)) begin
        fault <= 1'b1;
        result <= 32'd0;
      end else if (bus_ack_in) begin
        result <= bus_we_out ? {31'd0, atom} : load;
        if (!bus_we_out && atom) begin
          resv_valid <= 1'b1;
          resv_addr <= bus_addr_out[31:2];
        end
        if (bus_we_out && !atom && resv_addr == bus_addr_out[31:2]) resv_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven directed check of mem_access_unit with TIMEOUT=8,
// plus hand sequences for reset-in-REQ and a request held through DONE.
module tb_mem_access_unit;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, mem_read = 0, mem_write = 0, atomic = 0, zero_ext = 0;
  logic [1:0] mmask = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic bus_ack = 0, bus_err = 0;
  logic stall, rdata_valid, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid), .mem_read_in(mem_read),
    .mem_write_in(mem_write), .atomic_in(atomic), .mmask_in(mmask), .zero_ext_in(zero_ext),
    .addr_in(addr), .wdata_in(wdata), .stall_out(stall), .rdata_out(rdata),
    .rdata_valid_out(rdata_valid), .fault_out(fault), .bus_req_out(bus_req),
    .bus_we_out(bus_we), .bus_addr_out(bus_addr), .bus_be_out(bus_be),
    .bus_wdata_out(bus_wdata), .bus_ack_in(bus_ack), .bus_rdata_in(bus_rdata),
    .bus_err_in(bus_err)
  );
  typedef struct {
    logic rd, wr, at;
    logic [1:0] mm;
    logic zx;
    logic [31:0] addr, wd, brd;
    int lat;
    logic ack, err;
    logic [3:0] be;
    logic [31:0] ewd, erd;
    logic flt;
    int nreq;
  } vec_t;
  vec_t v[25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic run(input int idx, input vec_t t);
    int nreq = 0, stalls = 0;
    bit done = 0;
    string s = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1; mem_read = t.rd; mem_write = t.wr; atomic = t.at; mmask = t.mm;
    zero_ext = t.zx; addr = t.addr; wdata = t.wd;
    #1 stalls = int'(stall);
    @(negedge clk);
    req_valid = 0; mem_read = 0; mem_write = 0; atomic = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus_req) begin
        nreq++;
        stalls += int'(stall);
        chk({s, " be"}, {28'd0, bus_be}, {28'd0, t.be});
        chk({s, " addr"}, bus_addr, {t.addr[31:2], 2'b00});
        chk({s, " we"}, {31'd0, bus_we}, {31'd0, t.wr});
        if (t.wr) chk({s, " wdata"}, bus_wdata, t.ewd);
        bus_ack = t.ack && nreq == t.lat;
        bus_err = t.err && nreq == t.lat;
        bus_rdata = t.brd;
        @(negedge clk);
        bus_ack = 0; bus_err = 0;
      end else begin
        done = 1;
        chk({s, " valid"}, {31'd0, rdata_valid}, 32'd1);
        chk({s, " rdata"}, rdata, t.erd);
        chk({s, " fault"}, {31'd0, fault}, {31'd0, t.flt});
        chk({s, " done_stall"}, {31'd0, stall}, 32'd0);
        chk({s, " nreq"}, nreq, t.nreq);
        chk({s, " stalls"}, stalls, 1 + t.nreq);
      end
    end
    if (!done) chk({s, " completion_bound"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({s, " valid_pulse"}, {31'd0, rdata_valid}, 32'd0);
  endtask
  initial begin
    //        rd wr at mm zx addr         wdata        bus_rdata    lat ack err be       ewd          erd        flt nreq
    v[0]  = '{1, 0, 0, 0, 1, 32'h1003, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1000, 32'h0,        32'h00000080, 0, 1};
    v[1]  = '{1, 0, 0, 0, 0, 32'h1003, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 1};
    v[2]  = '{1, 0, 0, 1, 0, 32'h1002, 32'h0,        32'h80FF1234, 2, 1, 0, 4'b1100, 32'h0,        32'hFFFF80FF, 0, 2};
    v[3]  = '{1, 0, 0, 1, 1, 32'h1000, 32'h0,        32'h80FF9234, 1, 1, 0, 4'b0011, 32'h0,        32'h00009234, 0, 1};
    v[4]  = '{1, 0, 0, 2, 0, 32'h1004, 32'h0,        32'hDEADBEEF, 1, 1, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 1};
    v[5]  = '{1, 0, 0, 0, 0, 32'h1001, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b0010, 32'h0,        32'h00000012, 0, 1};
    v[6]  = '{0, 1, 0, 1, 0, 32'h2002, 32'h0000BEEF, 32'h0,        3, 1, 0, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 3};
    v[7]  = '{0, 1, 0, 0, 0, 32'h2001, 32'h123456AB, 32'h0,        1, 1, 0, 4'b0010, 32'hABABABAB, 32'h0,        0, 1};
    v[8]  = '{0, 1, 0, 3, 0, 32'h2000, 32'hCAFEF00D, 32'h0,        1, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 1};
    v[9]  = '{1, 0, 0, 2, 0, 32'h4002, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0};
    v[10] = '{1, 0, 0, 1, 0, 32'h4001, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0};
    v[11] = '{1, 0, 0, 2, 0, 32'h5000, 32'h0,        32'h12345678, 2, 0, 1, 4'b1111, 32'h0,        32'h0,        1, 2};
    v[12] = '{1, 0, 0, 2, 0, 32'h5004, 32'h0,        32'h12345678, 0, 0, 0, 4'b1111, 32'h0,        32'h0,        1, 8};
    v[13] = '{1, 0, 0, 2, 0, 32'h5008, 32'h0,        32'h12345678, 1, 1, 1, 4'b1111, 32'h0,        32'h0,        1, 1};
    v[14] = '{1, 0, 0, 2, 0, 32'h500C, 32'h0,        32'h12345678, 8, 1, 0, 4'b1111, 32'h0,        32'h12345678, 0, 8};
    v[15] = '{1, 0, 1, 2, 0, 32'h3000, 32'h0,        32'h11112222, 1, 1, 0, 4'b1111, 32'h0,        32'h11112222, 0, 1};
    v[16] = '{0, 1, 1, 2, 0, 32'h3000, 32'h00000055, 32'h0,        1, 1, 0, 4'b1111, 32'h00000055, 32'h1,        0, 1};
    v[17] = '{0, 1, 1, 2, 0, 32'h3000, 32'h00000066, 32'h0,        1, 1, 0, 4'b1111, 32'h00000066, 32'h0,        0, 0};
    v[18] = '{1, 0, 1, 2, 0, 32'h3000, 32'h0,        32'hA5A5A5A5, 1, 1, 0, 4'b1111, 32'h0,        32'hA5A5A5A5, 0, 1};
    v[19] = '{0, 1, 0, 2, 0, 32'h3000, 32'h77777777, 32'h0,        1, 1, 0, 4'b1111, 32'h77777777, 32'h0,        0, 1};
    v[20] = '{0, 1, 1, 2, 0, 32'h3000, 32'h00000088, 32'h0,        1, 1, 0, 4'b1111, 32'h00000088, 32'h0,        0, 0};
    v[21] = '{1, 0, 1, 0, 0, 32'h3001, 32'h0,        32'h0,        1, 1, 0, 4'b1111, 32'h0,        32'h0,        1, 0};
    v[22] = '{1, 0, 1, 0, 1, 32'h3000, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1111, 32'h0,        32'h80FF1234, 0, 1};
    v[23] = '{0, 1, 0, 2, 0, 32'h3004, 32'h01020304, 32'h0,        1, 1, 0, 4'b1111, 32'h01020304, 32'h0,        0, 1};
    v[24] = '{0, 1, 1, 2, 0, 32'h3000, 32'h00000099, 32'h0,        2, 1, 0, 4'b1111, 32'h00000099, 32'h1,        0, 2};
    #12;
    chk("reset bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset valid_fault", {30'd0, rdata_valid, fault}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset bus_fields", {bus_we, bus_be, 27'd0}, 32'd0);
    chk("reset bus_addr_wdata", bus_addr | bus_wdata, 32'd0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 25; i++) run(i, v[i]);
    // reset asserted between edges while a read is outstanding
    @(negedge clk);
    req_valid = 1; mem_read = 1; mmask = 2'd2; addr = 32'h6000;
    @(negedge clk);
    req_valid = 0; mem_read = 0;
    chk("rst_mid bus_req_before", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid stall", {31'd0, stall}, 32'd0);
    chk("rst_mid valid_fault", {30'd0, rdata_valid, fault}, 32'd0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("rst_after bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_after valid", {31'd0, rdata_valid}, 32'd0);
    // request held high through DONE must not start a new access
    @(negedge clk);
    req_valid = 1; mem_read = 1; mmask = 2'd2; addr = 32'h7000;
    @(negedge clk);
    chk("done_hold req", {31'd0, bus_req}, 32'd1);
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_ack = 0;
    chk("done_hold valid", {31'd0, rdata_valid}, 32'd1);
    chk("done_hold rdata", rdata, 32'h0BADF00D);
    chk("done_hold stall", {31'd0, stall}, 32'd0);
    req_valid = 0; mem_read = 0;
    @(negedge clk);
    chk("done_hold no_new_req", {31'd0, bus_req}, 32'd0);
    chk("done_hold idle_stall", {31'd0, stall}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
